// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer drain controller: pops one entry at a time from the store
// buffer and presents it as a single write cycle on the data bus. A bus
// error parks the controller in ERR until software clears it.
// Optional feature: define MOR1KX_STORE_DRAIN_TIMEOUT_EN to add a bus
// watchdog that turns a stalled write into a timeout error.
//
// state | meaning
// IDLE  | waiting for an entry; pops it when drain is enabled
// LOAD  | popped entry is on the inputs; capture it
// BUS   | write request on the data bus until ack, err or timeout
// ERR   | failing entry's pc/adr held for software; no pops
module mor1kx_store_buffer_drain #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int TIMEOUT_WIDTH        = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
   input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
   input  logic                              sb_atomic_i,
   input  logic                              sb_empty_i,
   output logic                              sb_read_o,
   input  logic                              drain_en_i,
   output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
   output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
   output logic                              dbus_req_o,
   output logic                              dbus_we_o,
   output logic                              dbus_atomic_o,
   input  logic                              dbus_ack_i,
   input  logic                              dbus_err_i,
   output logic                              err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
   output logic                              timeout_o,
   input  logic                              err_clear_i,
   output logic                              idle_o
);

   localparam int W  = OPTION_OPERAND_WIDTH;
   localparam int BW = OPTION_OPERAND_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, LOAD, BUS, ERR} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    pc_q, pc_d;
   logic [W-1:0]    adr_q, adr_d;
   logic [W-1:0]    dat_q, dat_d;
   logic [BW-1:0]   bsel_q, bsel_d;
   logic            atomic_q, atomic_d;
   logic            req_q, req_d;
   logic            err_q, err_d;
   logic            timeout_q, timeout_d;
   logic [W-1:0]    err_pc_q, err_pc_d;
   logic [W-1:0]    err_adr_q, err_adr_d;
   logic            pop;

`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
`else
   // Watchdog width only matters when the watchdog is compiled in.
   logic [TIMEOUT_WIDTH-1:0] wdog_unused;
   assign wdog_unused = '0;
`endif

   // Gating with rst keeps an entry from being popped and then lost to reset.
   assign pop = (state_q == IDLE) && !sb_empty_i && drain_en_i && !rst;

   // Next-state, entry capture and error capture.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      bsel_d    = bsel_q;
      atomic_d  = atomic_q;
      timeout_d = timeout_q;
      err_pc_d  = err_pc_q;
      err_adr_d = err_adr_q;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
      wdog_d    = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            if (pop) state_d = LOAD;
         end
         LOAD: begin
            pc_d     = sb_pc_i;
            adr_d    = sb_adr_i;
            dat_d    = sb_dat_i;
            bsel_d   = sb_bsel_i;
            atomic_d = sb_atomic_i;
            state_d  = BUS;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
            wdog_d   = '0;
`endif
         end
         BUS: begin
            if (dbus_err_i) begin
               state_d   = ERR;
               timeout_d = 1'b0;
               err_pc_d  = pc_q;
               err_adr_d = adr_q;
            end else if (dbus_ack_i) begin
               state_d = IDLE;
            end else begin
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
               wdog_d = wdog_q + 1'b1;
               if (&wdog_d) begin
                  state_d   = ERR;
                  timeout_d = 1'b1;
                  err_pc_d  = pc_q;
                  err_adr_d = adr_q;
               end
`endif
            end
         end
         ERR: begin
            if (err_clear_i) begin
               state_d   = IDLE;
               timeout_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus request and error flag are registered decodes of the next state.
   assign req_d = (state_d == BUS);
   assign err_d = (state_d == ERR);

   // All state, with synchronous reset discarding any in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         bsel_q    <= '0;
         atomic_q  <= 1'b0;
         req_q     <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         err_pc_q  <= '0;
         err_adr_q <= '0;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
         wdog_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         bsel_q    <= bsel_d;
         atomic_q  <= atomic_d;
         req_q     <= req_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
         err_pc_q  <= err_pc_d;
         err_adr_q <= err_adr_d;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

   assign sb_read_o     = pop;
   assign dbus_adr_o    = adr_q;
   assign dbus_dat_o    = dat_q;
   assign dbus_bsel_o   = bsel_q;
   assign dbus_req_o    = req_q;
   assign dbus_we_o     = req_q;
   assign dbus_atomic_o = req_q & atomic_q;
   assign err_o         = err_q;
   assign err_pc_o      = err_pc_q;
   assign err_adr_o     = err_adr_q;
   assign timeout_o     = timeout_q;
   assign idle_o        = (state_q == IDLE) && sb_empty_i;

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Bench for mor1kx_store_buffer_drain: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the drain controller.
module tb_mor1kx_store_buffer_drain;

   localparam int TW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sb_pc_i, sb_adr_i, sb_dat_i;
   logic [3:0]  sb_bsel_i;
   logic        sb_atomic_i, sb_empty_i, sb_read_o, drain_en_i;
   logic [31:0] dbus_adr_o, dbus_dat_o;
   logic [3:0]  dbus_bsel_o;
   logic        dbus_req_o, dbus_we_o, dbus_atomic_o, dbus_ack_i, dbus_err_i;
   logic        err_o, timeout_o, err_clear_i, idle_o;
   logic [31:0] err_pc_o, err_adr_o;

   int vectors = 0;
   int miscompares = 0;

   mor1kx_store_buffer_drain #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_WIDTH(TW)) dut (
      .clk(clk), .rst(rst),
      .sb_pc_i(sb_pc_i), .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i),
      .sb_bsel_i(sb_bsel_i), .sb_atomic_i(sb_atomic_i),
      .sb_empty_i(sb_empty_i), .sb_read_o(sb_read_o), .drain_en_i(drain_en_i),
      .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o), .dbus_bsel_o(dbus_bsel_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_atomic_o(dbus_atomic_o),
      .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
      .err_o(err_o), .err_pc_o(err_pc_o), .err_adr_o(err_adr_o),
      .timeout_o(timeout_o), .err_clear_i(err_clear_i), .idle_o(idle_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // The model tracks where the current entry is (popped, on the bus,
   // failed) and how many bus cycles it has waited.
   bit          m_started = 0;
   bit          m_popped = 0, m_on_bus = 0, m_failed = 0, m_tmo = 0;
   logic [31:0] e_pc = '0, e_adr = '0, e_dat = '0, m_epc = '0, m_eadr = '0;
   logic [3:0]  e_bsel = '0;
   bit          e_atomic = 0;
   int          m_wait = 0;

   function automatic bit m_idle();
      return !(m_popped || m_on_bus || m_failed);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_started = 1; m_popped = 0; m_on_bus = 0; m_failed = 0; m_tmo = 0;
         e_pc = '0; e_adr = '0; e_dat = '0; e_bsel = '0; e_atomic = 0;
         m_epc = '0; m_eadr = '0; m_wait = 0;
      end else if (m_popped) begin
         e_pc = sb_pc_i; e_adr = sb_adr_i; e_dat = sb_dat_i;
         e_bsel = sb_bsel_i; e_atomic = sb_atomic_i;
         m_popped = 0; m_on_bus = 1; m_wait = 0;
      end else if (m_on_bus) begin
         if (dbus_err_i) begin
            m_on_bus = 0; m_failed = 1; m_tmo = 0; m_epc = e_pc; m_eadr = e_adr;
         end else if (dbus_ack_i) begin
            m_on_bus = 0;
         end else begin
            m_wait++;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
            if (m_wait == (1 << TW) - 1) begin
               m_on_bus = 0; m_failed = 1; m_tmo = 1; m_epc = e_pc; m_eadr = e_adr;
            end
`endif
         end
      end else if (m_failed) begin
         if (err_clear_i) begin
            m_failed = 0; m_tmo = 0;
         end
      end else if (!sb_empty_i && drain_en_i) begin
         m_popped = 1;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("m_sb_read", {31'b0, sb_read_o}, {31'b0, m_idle() && !sb_empty_i && drain_en_i && !rst});
         chk("m_idle", {31'b0, idle_o}, {31'b0, m_idle() && sb_empty_i});
         chk("m_req", {31'b0, dbus_req_o}, {31'b0, m_on_bus});
         chk("m_we", {31'b0, dbus_we_o}, {31'b0, m_on_bus});
         chk("m_atomic", {31'b0, dbus_atomic_o}, {31'b0, m_on_bus && e_atomic});
         chk("m_err", {31'b0, err_o}, {31'b0, m_failed});
         chk("m_timeout", {31'b0, timeout_o}, {31'b0, m_tmo});
         chk("m_err_pc", err_pc_o, m_epc);
         chk("m_err_adr", err_adr_o, m_eadr);
         if (m_on_bus) begin
            chk("m_adr", dbus_adr_o, e_adr);
            chk("m_dat", dbus_dat_o, e_dat);
            chk("m_bsel", {28'b0, dbus_bsel_o}, {28'b0, e_bsel});
         end
      end
   end

   // ---------------- directed helpers ----------------
   // Called at posedge+1; presents one entry, acks (or errs) on the
   // (delay+1)-th bus cycle and reports what happened, cycle 0 = entry shown.
   task automatic do_store(input logic [31:0] pc, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] bsel,
                           input bit atom, input int delay, input bit with_err,
                           output int pops, output int reqc, output int pop_at,
                           output int req_at, output int end_at, output bit stable);
      bit done;
      pops = 0; reqc = 0; pop_at = -1; req_at = -1; end_at = -1; stable = 1; done = 0;
      sb_pc_i = pc; sb_adr_i = adr; sb_dat_i = dat; sb_bsel_i = bsel; sb_atomic_i = atom;
      sb_empty_i = 0; drain_en_i = 1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (sb_read_o) begin
            pops++;
            if (pop_at < 0) pop_at = i;
         end
         if (dbus_req_o) begin
            if (req_at < 0) req_at = i;
            reqc++;
            if (dbus_adr_o !== adr || dbus_dat_o !== dat || dbus_bsel_o !== bsel ||
                dbus_atomic_o !== atom || dbus_we_o !== 1'b1) stable = 0;
            if (reqc == delay + 1) begin
               #1;
               dbus_ack_i = 1;
               dbus_err_i = with_err;
            end
         end else if (reqc > 0 || err_o) begin
            done = 1;
            end_at = i;
         end
         @(posedge clk); #1;
         if (pops > 0) sb_empty_i = 1;
         dbus_ack_i = 0;
         dbus_err_i = 0;
      end
      if (!done) chk("store_completes", 32'd0, 32'd1);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   int pops, reqc, pop_at, req_at, end_at, cnt;
   bit stable;

   initial begin
      rst = 1; sb_pc_i = '0; sb_adr_i = '0; sb_dat_i = '0; sb_bsel_i = '0;
      sb_atomic_i = 0; sb_empty_i = 1; drain_en_i = 0;
      dbus_ack_i = 0; dbus_err_i = 0; err_clear_i = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // reset state
      @(negedge clk);
      chk("rst_req", {31'b0, dbus_req_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
      chk("rst_err_pc", err_pc_o, 32'd0);
      chk("rst_idle", {31'b0, idle_o}, 32'd1);
      step();

      // single store, ack in first bus cycle
      do_store(32'h1000, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0,
               pops, reqc, pop_at, req_at, end_at, stable);
      chk("s1_pop_at", pop_at, 32'd0);
      chk("s1_req_at", req_at, 32'd2);
      chk("s1_reqc", reqc, 32'd1);
      chk("s1_end_at", end_at, 32'd3);
      chk("s1_pops", pops, 32'd1);
      chk("s1_stable", {31'b0, stable}, 32'd1);

      // ack delayed by 5 cycles, atomic entry
      do_store(32'h1004, 32'h200, 32'h12345678, 4'h3, 1, 5, 0,
               pops, reqc, pop_at, req_at, end_at, stable);
      chk("s2_reqc", reqc, 32'd6);
      chk("s2_pops", pops, 32'd1);
      chk("s2_stable", {31'b0, stable}, 32'd1);
      chk("s2_end_at", end_at, 32'd8);

      // error and ack together: error wins
      do_store(32'h2000, 32'h104, 32'hCAFEF00D, 4'hC, 0, 0, 1,
               pops, reqc, pop_at, req_at, end_at, stable);
      chk("s3_err", {31'b0, err_o}, 32'd1);
      chk("s3_err_pc", err_pc_o, 32'h2000);
      chk("s3_err_adr", err_adr_o, 32'h104);
      chk("s3_timeout", {31'b0, timeout_o}, 32'd0);
      sb_empty_i = 0; drain_en_i = 1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (sb_read_o) cnt++;
         chk("s3_err_hold", {31'b0, err_o}, 32'd1);
         step();
      end
      chk("s3_no_pops", cnt, 32'd0);
      sb_empty_i = 1; err_clear_i = 1;
      step();
      err_clear_i = 0;
      @(negedge clk);
      chk("s3_cleared", {31'b0, err_o}, 32'd0);
      chk("s3_idle", {31'b0, idle_o}, 32'd1);
      step();

      // long bus stall, then reset in BUS
      sb_pc_i = 32'h3000; sb_adr_i = 32'h300; sb_dat_i = 32'hA5A5A5A5; sb_bsel_i = 4'h1;
      sb_atomic_i = 1; sb_empty_i = 0; drain_en_i = 1;
      step();
      sb_empty_i = 1;
      step();
      cnt = 0;
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
      for (int i = 0; i < 5; i++) begin
`else
      for (int i = 0; i < 100; i++) begin
`endif
         @(negedge clk);
         if (dbus_req_o) cnt++;
         step();
      end
`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
      chk("stall_req_cycles", cnt, 32'd5);
`else
      chk("stall_req_cycles", cnt, 32'd100);
`endif
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      chk("brst_req", {31'b0, dbus_req_o}, 32'd0);
      chk("brst_we", {31'b0, dbus_we_o}, 32'd0);
      chk("brst_atomic", {31'b0, dbus_atomic_o}, 32'd0);
      chk("brst_err_pc", err_pc_o, 32'd0);
      chk("brst_err_adr", err_adr_o, 32'd0);
      chk("brst_idle", {31'b0, idle_o}, 32'd1);
      step();

`ifdef MOR1KX_STORE_DRAIN_TIMEOUT_EN
      // watchdog fires after 2**TW-1 bus cycles
      do_store(32'h4000, 32'h400, 32'h0, 4'hF, 0, 1000, 0,
               pops, reqc, pop_at, req_at, end_at, stable);
      chk("tmo_reqc", reqc, 32'd15);
      chk("tmo_err", {31'b0, err_o}, 32'd1);
      chk("tmo_flag", {31'b0, timeout_o}, 32'd1);
      chk("tmo_err_adr", err_adr_o, 32'h400);
      err_clear_i = 1;
      step();
      err_clear_i = 0;
      @(negedge clk);
      chk("tmo_cleared", {31'b0, timeout_o}, 32'd0);
      step();
`endif

      // drain disabled holds off pops
      sb_empty_i = 0; drain_en_i = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_no_pop", {31'b0, sb_read_o}, 32'd0);
         chk("hold_not_idle", {31'b0, idle_o}, 32'd0);
         step();
      end
      drain_en_i = 1;
      @(negedge clk);
      chk("hold_pop", {31'b0, sb_read_o}, 32'd1);
      step();
      sb_empty_i = 1; dbus_ack_i = 1;
      repeat (3) @(negedge clk);
      chk("hold_done_idle", {31'b0, idle_o}, 32'd1);
      step();
      dbus_ack_i = 0;

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 500; i++) begin
         rst         = ($urandom_range(0, 99) == 0);
         sb_empty_i  = ($urandom_range(0, 2) == 0);
         drain_en_i  = ($urandom_range(0, 3) != 0);
         dbus_ack_i  = ($urandom_range(0, 2) == 0);
         dbus_err_i  = ($urandom_range(0, 9) == 0);
         err_clear_i = ($urandom_range(0, 3) == 0);
         sb_pc_i     = $urandom;
         sb_adr_i    = $urandom;
         sb_dat_i    = $urandom;
         sb_bsel_i   = 4'($urandom_range(0, 15));
         sb_atomic_i = $urandom_range(0, 1) == 1;
         step();
      end
      rst = 0; dbus_ack_i = 0; dbus_err_i = 0; err_clear_i = 0; sb_empty_i = 1;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mor1kx_store_buffer_drain.md
MOR1KX_STORE_BUFFER_DRAIN -- requirements
Module: mor1kx_store_buffer_drain

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, width of pc, address and data.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 8, width of bus watchdog counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports sb_pc_i, sb_adr_i, sb_dat_i  input  OPTION_OPERAND_WIDTH each  store buffer entry fields.
REQ-006 SHALL have ports sb_bsel_i  input  OPTION_OPERAND_WIDTH/8  and sb_atomic_i  input  1  entry byte select and atomic flag.
REQ-007 SHALL have ports sb_empty_i  input  1  (buffer empty) and sb_read_o  output  1  (one-cycle pop strobe).
REQ-008 SHALL have port drain_en_i  input  1  permits starting a new entry.
REQ-009 SHALL have ports dbus_adr_o, dbus_dat_o  output  OPTION_OPERAND_WIDTH  bus address and write data.
REQ-010 SHALL have ports dbus_bsel_o  output  OPTION_OPERAND_WIDTH/8, dbus_req_o, dbus_we_o, dbus_atomic_o  output  1  bus request, write enable, lock.
REQ-011 SHALL have ports dbus_ack_i, dbus_err_i  input  1  bus completion and error.
REQ-012 SHALL have ports err_o  output  1, err_pc_o, err_adr_o  output  OPTION_OPERAND_WIDTH, timeout_o  output  1, err_clear_i  input  1.
REQ-013 SHALL have port idle_o  output  1  no store in flight and sb_empty_i high.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, BUS, ERR.
REQ-015 IDLE: sb_read_o = !sb_empty_i && drain_en_i (combinational); when asserted, next state LOAD; otherwise remain IDLE.
REQ-016 LOAD: entry fields are valid this cycle; SHALL register pc, adr, dat, bsel, atomic; next state BUS; sb_read_o low.
REQ-017 BUS: dbus_req_o and dbus_we_o high, dbus_adr/dat/bsel/atomic_o driven from registered entry, stable until exit.
REQ-018 BUS: dbus_err_i high -> ERR (err priority over simultaneous ack); else dbus_ack_i high -> IDLE; else remain.
REQ-019 Throughput: one store per 3 cycles minimum (IDLE pop, LOAD, BUS with same-cycle ack); no back-to-back pipelining.
REQ-020 ERR: err_o high, err_pc_o/err_adr_o hold failing entry pc/adr, dbus_req_o low, no pops; err_clear_i -> IDLE next cycle.
REQ-021 err_clear_i outside ERR SHALL be ignored; drain_en_i low SHALL NOT abort LOAD or BUS.
REQ-022 dbus_we_o SHALL equal dbus_req_o; dbus_atomic_o SHALL be low outside BUS.
REQ-023 idle_o = (state == IDLE) && sb_empty_i.
REQ-024 ack or err outside BUS SHALL be ignored.

Reset
REQ-025 rst high SHALL force IDLE on next edge from any state, aborting any in-flight bus cycle (entry discarded).
REQ-026 After reset: dbus_req_o, dbus_we_o, dbus_atomic_o, sb_read_o, err_o, timeout_o = 0; registered pc/adr/dat/bsel, err_pc_o, err_adr_o = 0; watchdog = 0.

Configuration
REQ-027 Macro MOR1KX_STORE_DRAIN_TIMEOUT_EN SHALL compile in the bus watchdog.
REQ-028 With macro: TIMEOUT_WIDTH-bit counter cleared on entering BUS, increments each BUS cycle without ack/err; reaching all-ones -> ERR with timeout_o high (cleared with err_o).
REQ-029 Without macro: no counter, BUS waits indefinitely, timeout_o tied 0; ports unchanged.

Verification
REQ-030 sb_empty_i=0, drain_en_i=1, entry adr=0x100 dat=0xDEADBEEF bsel=0xF, ack in first BUS cycle -> sb_read_o pulse cycle 0, dbus_req_o cycle 2 only, back to IDLE cycle 3.
REQ-031 Ack delayed 5 cycles -> dbus_req_o high 6 cycles, outputs stable, exactly one sb_read_o pulse.
REQ-032 dbus_err_i and dbus_ack_i high together, pc=0x2000 adr=0x104 -> err_o=1, err_pc_o=0x2000, err_adr_o=0x104, no pops until err_clear_i, then IDLE.
REQ-033 With MOR1KX_STORE_DRAIN_TIMEOUT_EN, TIMEOUT_WIDTH=4, no ack -> ERR after 15 BUS cycles, timeout_o=1; without macro, dbus_req_o stays high 100 cycles.
REQ-034 rst asserted during BUS -> next cycle dbus_req_o=0, state IDLE, all outputs at reset values.
REQ-035 drain_en_i=0 with sb_empty_i=0 -> no sb_read_o, idle_o=0; drain_en_i=1 -> pop next cycle.
